// File: rtl/serial_divide_seq.sv
// Request sequencer in front of serial_divide_uu: buffers operand pairs in a
// small FIFO, runs one division at a time and returns quotient plus tag.
module serial_divide_seq #(
  parameter int M_PP         = 16,
  parameter int N_PP         = 8,
  parameter int Q_PP         = 16,
  parameter int TAG_WIDTH_PP = 4,
  parameter int DEPTH_PP     = 4,
  parameter int PTR_WIDTH_PP = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [M_PP-1:0]         req_dividend_i,
  input  logic [N_PP-1:0]         req_divisor_i,
  input  logic [TAG_WIDTH_PP-1:0] req_tag_i,
  output logic                    div_divide_o,
  output logic [M_PP-1:0]         div_dividend_o,
  output logic [N_PP-1:0]         div_divisor_o,
  input  logic [Q_PP-1:0]         div_quotient_i,
  input  logic                    div_done_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [Q_PP-1:0]         rsp_quotient_o,
  output logic [TAG_WIDTH_PP-1:0] rsp_tag_o,
  output logic                    rsp_dz_o,
  output logic [PTR_WIDTH_PP:0]   level_o
);

  localparam logic [PTR_WIDTH_PP:0] DEPTH_L = (PTR_WIDTH_PP+1)'(DEPTH_PP);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_GUARD, S_WAIT, S_RESP} state_e;

  state_e                  state_q, state_d;
  logic [PTR_WIDTH_PP-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_WIDTH_PP:0]   level_q, level_d;
  logic                    divide_q, divide_d;
  logic [M_PP-1:0]         dvd_q, dvd_d;
  logic [N_PP-1:0]         dvs_q, dvs_d;
  logic [TAG_WIDTH_PP-1:0] tag_q, tag_d;
  logic [Q_PP-1:0]         quot_q, quot_d;
  logic                    dz_q, dz_d;

  logic [M_PP-1:0]         dvd_mem_q [DEPTH_PP];
  logic [N_PP-1:0]         dvs_mem_q [DEPTH_PP];
  logic [TAG_WIDTH_PP-1:0] tag_mem_q [DEPTH_PP];

  logic push, pop;

  // Ready comes straight from the registered level, so a pop while full
  // only frees a slot for the following cycle.
  assign req_ready_o = (level_q != DEPTH_L);
  assign push        = req_valid_i && req_ready_o;
  assign pop         = (state_q == S_IDLE) && (level_q != '0);

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    tag_d   = tag_q;
    quot_d  = quot_q;
    dz_d    = dz_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          dvd_d = dvd_mem_q[rd_ptr_q];
          dvs_d = dvs_mem_q[rd_ptr_q];
          tag_d = tag_mem_q[rd_ptr_q];
          if (dvs_mem_q[rd_ptr_q] == '0) begin
            quot_d  = '1;
            dz_d    = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: state_d = S_GUARD;
      // done is still the level left over from the previous division here
      S_GUARD: state_d = S_WAIT;
      S_WAIT: begin
        if (div_done_i) begin
          quot_d  = div_quotient_i;
          dz_d    = 1'b0;
          state_d = S_RESP;
        end
      end
      S_RESP: if (rsp_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    divide_d = (state_d == S_ISSUE);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      divide_q <= 1'b0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      tag_q    <= '0;
      quot_q   <= '0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      divide_q <= divide_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      tag_q    <= tag_d;
      quot_q   <= quot_d;
      dz_q     <= dz_d;
    end
  end

  // Storage needs no reset; emptiness is tracked by the pointers and level.
  always_ff @(posedge clk_i) begin
    if (push) begin
      dvd_mem_q[wr_ptr_q] <= req_dividend_i;
      dvs_mem_q[wr_ptr_q] <= req_divisor_i;
      tag_mem_q[wr_ptr_q] <= req_tag_i;
    end
  end

  assign div_divide_o   = divide_q;
  assign div_dividend_o = dvd_q;
  assign div_divisor_o  = dvs_q;
  assign rsp_valid_o    = (state_q == S_RESP);
  assign rsp_quotient_o = quot_q;
  assign rsp_tag_o      = tag_q;
  assign rsp_dz_o       = dz_q;
  assign level_o        = level_q;

endmodule
